// File: rtl/izz_block_sequencer.sv
// izz_block_sequencer: ping-pong block buffer and row sequencer feeding inverse_zigzag
module izz_block_sequencer #(
  parameter int BLKCNT_W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [511:0] blk_data,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [511:0] izz_data,
  output logic [14:0]  izz_addr,
  input  logic [63:0]  izz_row,
  output logic [63:0]  row_data,
  output logic         row_valid,
  input  logic         row_ready,
  output logic [2:0]   row_idx,
  output logic         row_last,
  output logic [1:0]   occupancy
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [511:0] bank0, bank1;
  logic [1:0] full, full_n;
  logic wr_ptr, rd_ptr, rd_ptr_n;
  logic [2:0] row_cnt, sel;
  logic [BLKCNT_W-1:0] blk_cnt;
  logic accept, adv, rel;
  assign blk_ready = ~full[wr_ptr];
  assign row_valid = state == STREAM;
  assign accept = blk_valid & blk_ready & ~clr;
  assign adv = row_valid & row_ready & ~clr;
  assign rel = adv & (row_cnt == 3'd7);
  // inverse_zigzag select is offset by four rows from the natural row number
  assign sel = row_cnt + 3'd4;
  assign izz_addr = {blk_cnt, sel};
  assign izz_data = rd_ptr ? bank1 : bank0;
  assign row_data = izz_row;
  assign row_idx = row_cnt;
  assign row_last = row_valid & (row_cnt == 3'd7);
  assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};
  // next state follows the buffer that will be read next, so a fresh block streams one cycle after accept
  always_comb begin
    full_n = full;
    if (rel) full_n[rd_ptr] = 1'b0;
    if (accept) full_n[wr_ptr] = 1'b1;
    if (clr) full_n = '0;
    rd_ptr_n = clr ? 1'b0 : rd_ptr ^ rel;
    state_n = full_n[rd_ptr_n] ? STREAM : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      full <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      row_cnt <= '0;
      blk_cnt <= '0;
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      state <= state_n;
      full <= full_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= clr ? 1'b0 : wr_ptr ^ accept;
      row_cnt <= clr ? '0 : row_cnt + {2'b0, adv};
      blk_cnt <= clr ? '0 : blk_cnt + {{(BLKCNT_W-1){1'b0}}, rel};
      if (accept && !wr_ptr) bank0 <= blk_data;
      if (accept && wr_ptr) bank1 <= blk_data;
    end
endmodule

// File: tb/tb_izz_block_sequencer.sv
// tb_izz_block_sequencer: scoreboard bench with an inverse_zigzag model and natural-order row reference
module tb_izz_block_sequencer;
  logic clk = 0, rst_n = 1, clr = 0, blk_valid = 0, row_ready = 1;
  logic blk_ready, row_valid, row_last;
  logic [511:0] blk_data = '0, izz_data;
  logic [14:0] izz_addr;
  logic [63:0] izz_row, row_data;
  logic [2:0] row_idx;
  logic [1:0] occupancy;
  int total = 0, bad = 0, occ_m = 0, mode = 0, cyc = 0;
  logic [11:0] acc_cnt = '0;
  typedef struct {logic [63:0] d; logic [2:0] idx; logic [11:0] blk;} exp_t;
  exp_t q[$];
  logic hold_v = 0;
  logic [63:0] hold_d;
  logic [2:0] hold_i;
  logic [3:0] pat = 4'b1001;

  izz_block_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .izz_data(izz_data), .izz_addr(izz_addr), .izz_row(izz_row),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_last(row_last), .occupancy(occupancy)
  );

  // zigzag scan index of natural position (i,j): diagonals alternate direction
  function automatic int zz_of(int i, int j);
    int s = i + j;
    int base = s <= 7 ? s * (s + 1) / 2 : 64 - (15 - s) * (16 - s) / 2;
    int off = (s % 2) ? i - (s > 7 ? s - 7 : 0) : (s < 7 ? s : 7) - i;
    return base + off;
  endfunction

  function automatic logic [63:0] nat_row(logic [511:0] d, int r);
    logic [63:0] o = '0;
    for (int c = 0; c < 8; c++) o[8*(8-c)-1 -: 8] = d[8*(64-zz_of(r, c))-1 -: 8];
    return o;
  endfunction

  function automatic logic [511:0] mk(int kind);
    logic [511:0] d = '0;
    for (int k = 0; k < 64; k++) d[8*(64-k)-1 -: 8] = 8'(kind == 0 ? k : kind == 1 ? 63 - k : $urandom);
    return d;
  endfunction

  assign izz_row = nat_row(izz_data, int'(izz_addr[2:0] ^ 3'd4));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 row_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc%4] : 1'($urandom_range(0, 1));
  end

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic flush();
    q.delete();
    occ_m = 0;
    acc_cnt = '0;
    hold_v = 0;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (clr) flush();
    else begin
      chk("occupancy", 64'(occupancy), 64'(occ_m));
      chk("blk_ready", 64'(blk_ready), 64'(occ_m < 2));
      chk("row_valid", 64'(row_valid), 64'(occ_m > 0));
      if (hold_v && row_valid) begin
        chk("stall_data", row_data, hold_d);
        chk("stall_idx", 64'(row_idx), 64'(hold_i));
      end
      hold_v = row_valid && !row_ready;
      hold_d = row_data;
      hold_i = row_idx;
      if (row_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_row act idx=%0d exp no row", row_idx);
        end else begin
          chk("row_data", row_data, q[0].d);
          chk("row_idx", 64'(row_idx), 64'(q[0].idx));
          chk("blk_cnt", 64'(izz_addr[14:3]), 64'(q[0].blk));
          chk("row_last", 64'(row_last), 64'(q[0].idx == 3'd7));
          if (row_ready) begin
            if (q[0].idx == 3'd7) occ_m--;
            void'(q.pop_front());
          end
        end
      end
      if (blk_valid && blk_ready) begin
        for (int r = 0; r < 8; r++) q.push_back('{nat_row(blk_data, r), 3'(r), acc_cnt});
        acc_cnt++;
        occ_m++;
      end
    end
  end

  task automatic send(input logic [511:0] d, output int n);
    blk_data = d;
    blk_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!blk_ready && n < 300);
    if (!blk_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=blocked exp=accepted");
    end
    @(posedge clk);
    #1 blk_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((q.size() != 0 || row_valid) && n < 2000);
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic wait_row(int r);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(row_valid && row_idx == 3'(r)) && n < 100);
    chk("wait_row", 64'(row_idx), 64'(r));
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_blk_ready"}, 64'(blk_ready), 64'(1));
    chk({n, "_row_valid"}, 64'(row_valid), 64'(0));
    chk({n, "_row_last"}, 64'(row_last), 64'(0));
    chk({n, "_row_idx"}, 64'(row_idx), 64'(0));
    chk({n, "_occupancy"}, 64'(occupancy), 64'(0));
    chk({n, "_izz_addr"}, 64'(izz_addr), 64'(15'h0004));
    chk({n, "_izz_data"}, 64'(izz_data == '0), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, mx;
    #1 rst_n = 0;
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(mk(0), w);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk("t1_valid", 64'(row_valid), 64'(1));
      chk("t1_sel", 64'(izz_addr[2:0]), 64'((r + 4) % 8));
      chk("t1_last", 64'(row_last), 64'(r == 7));
      if (r == 0) chk("t1_row0", row_data, 64'h000105060E0F1B1C);
      if (r == 7) chk("t1_row7", row_data, 64'h23243031393A3E3F);
    end
    wait_idle();
    send(mk(0), w);
    send(mk(1), w);
    n = 0;
    mx = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (row_valid) n++;
      if (int'(occupancy) > mx) mx = int'(occupancy);
    end
    chk("t2_contiguous", 64'(n), 64'(15));
    chk("t2_max_occ", 64'(mx), 64'(2));
    @(negedge clk);
    chk("t2_end_occ", 64'(occupancy), 64'(0));
    wait_idle();
    send(mk(2), w);
    send(mk(2), w);
    send(mk(2), w);
    chk("t3_wait", 64'(w), 64'(8));
    wait_idle();
    mode = 1;
    send(mk(2), w);
    send(mk(2), w);
    wait_idle();
    mode = 0;
    send(mk(2), w);
    send(mk(2), w);
    wait_row(2);
    @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("t5_row_valid", 64'(row_valid), 64'(0));
    chk("t5_occ", 64'(occupancy), 64'(0));
    chk("t5_blk_ready", 64'(blk_ready), 64'(1));
    chk("t5_izz_addr", 64'(izz_addr), 64'(15'h0004));
    wait_idle();
    send(mk(2), w);
    wait_row(3);
    #2 rst_n = 0;
    #1 chk_reset_outs("t6");
    flush();
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    send(mk(2), w);
    @(negedge clk);
    chk("t6_row_idx", 64'(row_idx), 64'(0));
    chk("t6_izz_addr", 64'(izz_addr), 64'(15'h0004));
    wait_idle();
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      send(mk(2), w);
    end
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
